// File: rtl/conv_window_read_addr_gen_pkg.sv
// Shared types and helpers for the convolution window read address generator.
package conv_addr_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} rag_state_t;

   // Width of a counter that must hold 0..n-1; never narrower than one bit.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/conv_window_read_addr_gen_if.sv
// Read-request bus between the window address generator and the conv datapath.
// With ZERO_PAD_EN defined the bus also carries pad_tap.
interface conv_window_read_addr_gen_if #(
   parameter int ADDR_SIZE = 4
);
   logic                 start;
   logic                 rd_ready;
   logic                 rd_en;
   logic [ADDR_SIZE-1:0] rd_addr;
   logic                 first_tap;
   logic                 last_tap;
   logic                 busy;
   logic                 frame_done;
`ifdef ZERO_PAD_EN
   logic                 pad_tap;

   modport master (input  start, rd_ready,
                   output rd_en, rd_addr, first_tap, last_tap, busy, frame_done, pad_tap);
   modport slave  (output start, rd_ready,
                   input  rd_en, rd_addr, first_tap, last_tap, busy, frame_done, pad_tap);
`else
   modport master (input  start, rd_ready,
                   output rd_en, rd_addr, first_tap, last_tap, busy, frame_done);
   modport slave  (output start, rd_ready,
                   input  rd_en, rd_addr, first_tap, last_tap, busy, frame_done);
`endif
endinterface

// File: rtl/conv_window_read_addr_gen_window_tap_counter.sv
// Nested k_r/k_c tap counter for one KERNEL_SIZE x KERNEL_SIZE window, row-major.
// Exposes next-cycle values so a parent can register outputs derived from them.
module window_tap_counter
   import conv_addr_pkg::*;
#(
   parameter  int KERNEL_SIZE = 3,
   localparam int KW          = clog2_min1(KERNEL_SIZE)
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          i_advance,
   output logic [KW-1:0] o_k_r_nxt,
   output logic [KW-1:0] o_k_c_nxt,
   output logic          o_first_nxt,
   output logic          o_last_nxt,
   output logic          o_wrap
);
   localparam logic [KW-1:0] K_MAX = KW'(KERNEL_SIZE - 1);

   logic [KW-1:0] r_k_r;
   logic [KW-1:0] r_k_c;
   logic          w_c_end;
   logic          w_r_end;

   assign w_c_end = (r_k_c == K_MAX);
   assign w_r_end = (r_k_r == K_MAX);

   // Next tap: k_c steps, wrapping into k_r; both wrap to 0 after the last tap.
   always_comb begin
      // NOTE: defaults first so every path assigns every output -- no latch.
      o_k_r_nxt = r_k_r;
      o_k_c_nxt = r_k_c;
      if (i_advance) begin
         if (w_c_end) begin
            o_k_c_nxt = '0;
            o_k_r_nxt = w_r_end ? '0 : r_k_r + 1'b1;
         end else begin
            o_k_c_nxt = r_k_c + 1'b1;
         end
      end
   end

   // Tap counter registers.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking so every register samples pre-edge values.
      if (rst) begin
         r_k_r <= '0;
         r_k_c <= '0;
      end else begin
         r_k_r <= o_k_r_nxt;
         r_k_c <= o_k_c_nxt;
      end
   end

   assign o_first_nxt = (o_k_r_nxt == '0) && (o_k_c_nxt == '0);
   assign o_last_nxt  = (o_k_r_nxt == K_MAX) && (o_k_c_nxt == K_MAX);
   assign o_wrap      = i_advance && w_c_end && w_r_end;

endmodule

// File: rtl/conv_window_read_addr_gen.sv
// Sweeps every kernel window over a stored frame and issues one read address per tap.
// Optional feature: ZERO_PAD_EN enables "same" zero padding and the pad_tap output.
module conv_window_read_addr_gen
   import conv_addr_pkg::*;
#(
   parameter int IMG_ROWS    = 4,
   parameter int IMG_COLS    = 4,
   parameter int KERNEL_SIZE = 3,
   parameter int STRIDE      = 1,
   parameter int ADDR_SIZE   = 4
)(
   input logic                          clk,
   input logic                          rst,
   conv_window_read_addr_gen_if.master  rd_bus
);
`ifdef ZERO_PAD_EN
   localparam int PAD = (KERNEL_SIZE - 1) / 2;
`else
   localparam int PAD = 0;
`endif
   localparam int OUT_ROWS = (IMG_ROWS + 2 * PAD - KERNEL_SIZE) / STRIDE + 1;
   localparam int OUT_COLS = (IMG_COLS + 2 * PAD - KERNEL_SIZE) / STRIDE + 1;
   localparam int RW       = clog2_min1(OUT_ROWS);
   localparam int CW       = clog2_min1(OUT_COLS);
   localparam int KW       = clog2_min1(KERNEL_SIZE);
   localparam int AW2      = ADDR_SIZE + 2;
   localparam logic [RW-1:0] WR_MAX = RW'(OUT_ROWS - 1);
   localparam logic [CW-1:0] WC_MAX = CW'(OUT_COLS - 1);

   if (KERNEL_SIZE > IMG_ROWS || KERNEL_SIZE > IMG_COLS) begin : g_bad_kernel
      $error("KERNEL_SIZE must not exceed IMG_ROWS or IMG_COLS");
   end
   if (STRIDE < 1) begin : g_bad_stride
      $error("STRIDE must be at least 1");
   end

   rag_state_t           r_state, w_state_nxt;
   logic [RW-1:0]        r_win_r, w_win_r_nxt;
   logic [CW-1:0]        r_win_c, w_win_c_nxt;
   logic [KW-1:0]        w_k_r_nxt, w_k_c_nxt;
   logic                 w_first_nxt, w_last_nxt, w_wrap;
   logic                 w_adv, w_final, w_run_nxt, w_in_img_nxt;
   logic [AW2-1:0]       w_row_nxt, w_col_nxt;
   logic [ADDR_SIZE-1:0] w_addr_nxt;
   logic                 r_rd_en, r_first_tap, r_last_tap, r_busy, r_frame_done;
   logic [ADDR_SIZE-1:0] r_rd_addr;

   // A tap moves on when the consumer takes it, or at once when it is a pad tap.
   assign w_adv   = (r_state == RUN) && (rd_bus.rd_ready || !r_rd_en);
   assign w_final = w_wrap && (r_win_r == WR_MAX) && (r_win_c == WC_MAX);

   window_tap_counter #(.KERNEL_SIZE(KERNEL_SIZE)) u_tap_cnt (
      .clk         (clk),
      .rst         (rst),
      .i_advance   (w_adv),
      .o_k_r_nxt   (w_k_r_nxt),
      .o_k_c_nxt   (w_k_c_nxt),
      .o_first_nxt (w_first_nxt),
      .o_last_nxt  (w_last_nxt),
      .o_wrap      (w_wrap)
   );

   // Window origin steps when a window's last tap moves on; wraps to 0 after the frame.
   always_comb begin
      w_win_r_nxt = r_win_r;
      w_win_c_nxt = r_win_c;
      if (w_wrap) begin
         if (r_win_c == WC_MAX) begin
            w_win_c_nxt = '0;
            w_win_r_nxt = (r_win_r == WR_MAX) ? '0 : r_win_r + 1'b1;
         end else begin
            w_win_c_nxt = r_win_c + 1'b1;
         end
      end
   end

   // Sweep control: IDLE -> RUN on start, RUN -> DONE on final tap, DONE -> IDLE.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (rd_bus.start) w_state_nxt = RUN;
         RUN:     if (w_final)      w_state_nxt = DONE;
         DONE:                      w_state_nxt = IDLE;
         default:                   w_state_nxt = IDLE;
      endcase
   end

   // Tap coordinates of the next cycle; negative values wrap to large unsigned ones,
   // so a single unsigned bound check also rejects taps above/left of the image.
   assign w_row_nxt  = AW2'(w_win_r_nxt) * AW2'(STRIDE) + AW2'(w_k_r_nxt) - AW2'(PAD);
   assign w_col_nxt  = AW2'(w_win_c_nxt) * AW2'(STRIDE) + AW2'(w_k_c_nxt) - AW2'(PAD);
   assign w_addr_nxt = ADDR_SIZE'(w_row_nxt * AW2'(IMG_COLS) + w_col_nxt);
   assign w_run_nxt  = (w_state_nxt == RUN);
`ifdef ZERO_PAD_EN
   assign w_in_img_nxt = (w_row_nxt < AW2'(IMG_ROWS)) && (w_col_nxt < AW2'(IMG_COLS));
`else
   assign w_in_img_nxt = 1'b1;
`endif

   // State and window origin registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_win_r <= '0;
         r_win_c <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_win_r <= w_win_r_nxt;
         r_win_c <= w_win_c_nxt;
      end
   end

   // Output registers, loaded from next-cycle values so they line up with the counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_en      <= 1'b0;
         r_rd_addr    <= '0;
         r_first_tap  <= 1'b0;
         r_last_tap   <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_rd_en      <= w_run_nxt && w_in_img_nxt;
         r_first_tap  <= w_run_nxt && w_first_nxt;
         r_last_tap   <= w_run_nxt && w_last_nxt;
         r_busy       <= w_run_nxt;
         r_frame_done <= (w_state_nxt == DONE);
         if (w_run_nxt && w_in_img_nxt) r_rd_addr <= w_addr_nxt;
      end
   end

`ifdef ZERO_PAD_EN
   logic r_pad_tap;

   // Pad flag marks out-of-image taps, which are never offered to the buffer.
   always_ff @(posedge clk) begin
      if (rst) r_pad_tap <= 1'b0;
      else     r_pad_tap <= w_run_nxt && !w_in_img_nxt;
   end

   assign rd_bus.pad_tap = r_pad_tap;
`endif

   assign rd_bus.rd_en      = r_rd_en;
   assign rd_bus.rd_addr    = r_rd_addr;
   assign rd_bus.first_tap  = r_first_tap;
   assign rd_bus.last_tap   = r_last_tap;
   assign rd_bus.busy       = r_busy;
   assign rd_bus.frame_done = r_frame_done;

endmodule
